// File: rtl/rf_wb_arbiter.sv
// Merges pipe-0, pipe-1 and long-latency writebacks onto two register-file write ports.
// Pipe writes are combinational. Queued results reach a port no earlier than 1 cycle after acceptance.
// ll_ready drops when the queue is full. Option RF_WB_WAW_SQUASH_EN kills queued entries overwritten by a pipe.
module rf_wb_arbiter #(
    parameter int LL_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        p0_we,
    input  logic [4:0]                  p0_waddr,
    input  logic [31:0]                 p0_wdata,
    input  logic                        p1_we,
    input  logic [4:0]                  p1_waddr,
    input  logic [31:0]                 p1_wdata,
    input  logic                        ll_valid,
    output logic                        ll_ready,
    input  logic [4:0]                  ll_waddr,
    input  logic [31:0]                 ll_wdata,
    output logic                        we_01,
    output logic [4:0]                  waddr_01,
    output logic [31:0]                 wdata_01,
    output logic                        we_02,
    output logic [4:0]                  waddr_02,
    output logic [31:0]                 wdata_02,
    output logic [$clog2(LL_DEPTH):0]   pend_count,
    output logic [31:0]                 pend_mask
);
    localparam int AW = $clog2(LL_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(LL_DEPTH);

    logic [4:0]          q_addr [LL_DEPTH];
    logic [31:0]         q_data [LL_DEPTH];
    logic [LL_DEPTH-1:0] q_live;
    logic [AW-1:0]       rd_ptr, wr_ptr, rd_ptr2;
    logic [CW-1:0]       count;

    logic                p0e, p1e, has1, has2, enq;
    logic [1:0]          pops;
    logic [LL_DEPTH-1:0] occ, drain, kill;
    logic [AW-1:0]       off;

    assign p0e     = p0_we && (p0_waddr != 5'd0);
    assign p1e     = p1_we && (p1_waddr != 5'd0);
    assign has1    = (count != '0);
    assign has2    = (count >= CW'(2));
    assign rd_ptr2 = rd_ptr + AW'(1);

    // Readiness is purely registered state; reset only masks it.
    assign ll_ready   = ~reset && (count < DEPTH_C);
    assign enq        = ll_valid && ll_ready && (ll_waddr != 5'd0);
    assign pend_count = reset ? '0 : count;

    // Port assignment: oldest writer on port 1; dead entries still consume their slot.
    always_comb begin
        we_01    = 1'b0;
        waddr_01 = '0;
        wdata_01 = '0;
        we_02    = 1'b0;
        waddr_02 = '0;
        wdata_02 = '0;
        pops     = 2'd0;
        if (!reset) begin
            if (p0e && p1e) begin
                we_01 = 1'b1; waddr_01 = p0_waddr; wdata_01 = p0_wdata;
                we_02 = 1'b1; waddr_02 = p1_waddr; wdata_02 = p1_wdata;
            end else if (p0e || p1e) begin
                we_02    = 1'b1;
                waddr_02 = p0e ? p0_waddr : p1_waddr;
                wdata_02 = p0e ? p0_wdata : p1_wdata;
                if (has1) begin
                    pops = 2'd1;
                    if (q_live[rd_ptr]) begin
                        we_01 = 1'b1; waddr_01 = q_addr[rd_ptr]; wdata_01 = q_data[rd_ptr];
                    end
                end
            end else begin
                if (has1) begin
                    pops = 2'd1;
                    if (q_live[rd_ptr]) begin
                        we_01 = 1'b1; waddr_01 = q_addr[rd_ptr]; wdata_01 = q_data[rd_ptr];
                    end
                end
                if (has2) begin
                    pops = 2'd2;
                    if (q_live[rd_ptr2]) begin
                        we_02 = 1'b1; waddr_02 = q_addr[rd_ptr2]; wdata_02 = q_data[rd_ptr2];
                    end
                end
            end
        end
    end

    always_comb begin
        occ       = '0;
        drain     = '0;
        kill      = '0;
        off       = '0;
        pend_mask = '0;
        for (int i = 0; i < LL_DEPTH; i++) begin
            off      = AW'(i) - rd_ptr;
            occ[i]   = ({1'b0, off} < count);
            drain[i] = ({1'b0, off} < CW'(pops));
`ifdef RF_WB_WAW_SQUASH_EN
            // Only entries already queued and staying queued can be overtaken by a pipe write.
            kill[i]  = occ[i] && !drain[i] &&
                       ((p0e && (q_addr[i] == p0_waddr)) || (p1e && (q_addr[i] == p1_waddr)));
`endif
            if (occ[i] && q_live[i])
                pend_mask[q_addr[i]] = 1'b1;
        end
        if (reset)
            pend_mask = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            q_live <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(pops);
            wr_ptr <= wr_ptr + AW'(enq);
            count  <= count + CW'(enq) - CW'(pops);
            q_live <= q_live & ~kill;
            if (enq)
                q_live[wr_ptr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_addr[wr_ptr] <= ll_waddr;
            q_data[wr_ptr] <= ll_wdata;
        end
    end

endmodule
